// File: rtl/opcode_pkg.sv
// Instruction opcodes for the instruction unit.
// Code 4'hF is left undefined and decodes as illegal.
package opcode_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDR  = 4'h1,
    OP_STR  = 4'h2,
    OP_RES1 = 4'h3,
    OP_RES2 = 4'h4,
    OP_ADD  = 4'h5,
    OP_SUB  = 4'h6,
    OP_AND  = 4'h7,
    OP_OR   = 4'h8,
    OP_XOR  = 4'h9,
    OP_SP1  = 4'hA,
    OP_SP2  = 4'hB,
    OP_SP3  = 4'hC,
    OP_SP4  = 4'hD,
    OP_SP5  = 4'hE
  } opcode_t;

  function automatic logic is_alu(input opcode_t op);
    return (op >= OP_ADD) && (op <= OP_SP5);
  endfunction

endpackage

// File: rtl/system_widths_pkg.sv
// Shared widths, defaults and FSM states.
// Address field sits in instr[12:0], below rb.
package system_widths_pkg;

  localparam int ADDR_W          = 13;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int MEM_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE_MEM,
    ST_WAIT_MEM,
    ST_ISSUE_ALU,
    ST_WAIT_ALU,
    ST_DONE
  } state_t;

endpackage

// File: rtl/iu_miu_if.sv
// Byte-wide memory request channel between the
// instruction unit and the memory interface unit.
interface iu_miu_if;
  import system_widths_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_write;
  logic [7:0]        mem_read;
  logic              mem_done;

  modport iu (
    output mem_req, mem_we, mem_addr, mem_write,
    input  mem_read, mem_done
  );

  modport mem (
    input  mem_req, mem_we, mem_addr, mem_write,
    output mem_read, mem_done
  );
endinterface

// File: rtl/iu_instr_fifo.sv
// Instruction queue; pointers carry an extra wrap
// bit so full and empty are told apart.
module iu_instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/instruction_unit_q.sv
// Queued instruction unit: fetch, decode, then
// drive memory or ALU and write back to the regfile.
module instruction_unit_q
  import opcode_pkg::*;
  import system_widths_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
  parameter int LDR_SIGN_EXT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr_in,
  output logic              instr_ready,
  output logic              core_ready_flag,
  output logic              alu_busy_flag,
  output logic              mem_busy_flag,
  output logic              instruction_done_flag,
  output logic              illegal_opcode_flag,
  output logic              mem_timeout_flag,
  output logic [31:0]       retired_count,
  output logic [4:0]        rf_addr_a,
  output logic [4:0]        rf_addr_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic              rf_wen,
  output logic [4:0]        rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_done,
  iu_miu_if.iu              miu
);
  localparam int   TCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic SX  = (LDR_SIGN_EXT != 0);

  state_t            state_q;
  opcode_t           op_q, hop;
  logic [4:0]        rt_q, ra_q, rb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        sbyte_q;
  logic [DATA_W-1:0] wdata_q, ldr_data;
  logic              wb_q, ill_q, to_q;
  logic [TCW-1:0]    tcnt_q;
  logic              mreq_q, mwe_q;
  logic              done_q, rfwen_q, illf_q, tof_q;
  logic [31:0]       ret_q;
  logic [31:0]       head;
  logic              push, pop, full, empty, alu_st;

  assign instr_ready = !full;
  assign push        = instr_valid && !full;
  assign pop         = (state_q == ST_FETCH);
  assign hop         = opcode_t'(head[31:28]);

  iu_instr_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (instr_in),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign alu_st = (state_q == ST_ISSUE_ALU) ||
                  (state_q == ST_WAIT_ALU);

  assign core_ready_flag = (state_q == ST_IDLE) && empty;
  assign alu_busy_flag   = alu_st;
  assign mem_busy_flag   = (state_q == ST_ISSUE_MEM) ||
                           (state_q == ST_WAIT_MEM);

  assign instruction_done_flag = done_q;
  assign illegal_opcode_flag   = illf_q;
  assign mem_timeout_flag      = tof_q;
  assign retired_count         = ret_q;
  assign rf_wen                = rfwen_q;
  assign rf_write_addr         = rt_q;
  assign rf_write_data         = wdata_q;

  // FETCH reads rt so a store byte can be latched on the pop edge
  always_comb begin
    rf_addr_a = '0;
    rf_addr_b = '0;
    if (state_q == ST_FETCH) rf_addr_a = head[27:23];
    if (alu_st) begin
      rf_addr_a = ra_q;
      rf_addr_b = rb_q;
    end
  end

  assign alu_op = alu_st ? 4'(op_q) : 4'd0;
  assign alu_a  = alu_st ? rf_data_a : '0;
  assign alu_b  = alu_st ? rf_data_b : '0;

  assign ldr_data = {{(DATA_W-8){SX & miu.mem_read[7]}},
                     miu.mem_read};

  assign miu.mem_req   = mreq_q;
  assign miu.mem_we    = mwe_q;
  assign miu.mem_addr  = addr_q;
  assign miu.mem_write = sbyte_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      rt_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      addr_q  <= '0;
      sbyte_q <= '0;
      wdata_q <= '0;
      wb_q    <= 1'b0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      tcnt_q  <= '0;
      mreq_q  <= 1'b0;
      mwe_q   <= 1'b0;
      done_q  <= 1'b0;
      rfwen_q <= 1'b0;
      illf_q  <= 1'b0;
      tof_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      rfwen_q <= 1'b0;
      illf_q  <= 1'b0;
      tof_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (!empty) state_q <= ST_FETCH;
        ST_FETCH: begin
          op_q   <= hop;
          rt_q   <= head[27:23];
          ra_q   <= head[22:18];
          rb_q   <= head[17:13];
          addr_q <= head[ADDR_W-1:0];
          tcnt_q <= '0;
          unique case (1'b1)
            (hop == OP_NOP): state_q <= ST_DONE;
            (hop == OP_LDR) || (hop == OP_STR): begin
              state_q <= ST_ISSUE_MEM;
              mreq_q  <= 1'b1;
              mwe_q   <= (hop == OP_STR);
              if (hop == OP_STR) sbyte_q <= rf_data_a[7:0];
            end
            is_alu(hop): state_q <= ST_ISSUE_ALU;
            default: begin
              ill_q   <= 1'b1;
              state_q <= ST_DONE;
            end
          endcase
        end
        ST_ISSUE_MEM, ST_WAIT_MEM: begin
          if (miu.mem_done) begin
            mreq_q  <= 1'b0;
            mwe_q   <= 1'b0;
            state_q <= ST_DONE;
            if (op_q == OP_LDR) begin
              wb_q    <= 1'b1;
              wdata_q <= ldr_data;
            end
          end else if (state_q == ST_ISSUE_MEM) begin
            state_q <= ST_WAIT_MEM;
          end else if (tcnt_q == TCW'(MEM_TIMEOUT - 1)) begin
            mreq_q  <= 1'b0;
            mwe_q   <= 1'b0;
            to_q    <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            tcnt_q <= tcnt_q + TCW'(1);
          end
        end
        ST_ISSUE_ALU, ST_WAIT_ALU: begin
          if (alu_done) begin
            wb_q    <= 1'b1;
            wdata_q <= alu_result;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_WAIT_ALU;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          rfwen_q <= wb_q;
          illf_q  <= ill_q;
          tof_q   <= to_q;
          ret_q   <= ret_q + 32'd1;
          wb_q    <= 1'b0;
          ill_q   <= 1'b0;
          to_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_unit_q.sv
// Scoreboard bench: two DUTs in lockstep, zero-pad
// and sign-extend loads, checked by a negedge monitor.
module tb_instruction_unit_q;
  import opcode_pkg::*;

  typedef struct {
    logic wb;
    logic ill;
    logic to;
    logic lat;
    int   acc;
  } dexp_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d0;
    logic [31:0] d1;
  } wexp_t;

  logic        clk = 1'b0;
  logic        reset, instr_valid;
  logic [31:0] instr_in;
  logic [31:0] rf_a, rf_b, alu_res;
  logic        alu_done = 1'b0;

  logic        rdy0, crdy0, abusy0, mbusy0, done0, ill0, to0, wen0;
  logic [31:0] ret0, wd0, aa0, ab0;
  logic [4:0]  ra0, rb0, wa0;
  logic [3:0]  aop0;
  logic        rdy1, crdy1, abusy1, mbusy1, done1, ill1, to1, wen1;
  logic [31:0] ret1, wd1, aa1, ab1;
  logic [4:0]  ra1, rb1, wa1;
  logic [3:0]  aop1;

  logic [31:0] regs [32];
  logic        alu_stall, mem_en;
  int          mem_lat;
  logic [7:0]  rd_val;
  logic        exp_we;
  logic [12:0] exp_addr;
  logic [7:0]  exp_wr;
  logic        seen_we = 1'b0;
  logic [12:0] seen_addr = '0;
  logic [7:0]  seen_wr = '0;
  int          mcnt = 0, acnt = 0, mreq_n = 0, mem_unstable = 0;
  int          cyc = 0;
  int          total = 0, bad = 0;
  dexp_t       donq[$];
  wexp_t       wbq[$];

  iu_miu_if m0();
  iu_miu_if m1();
  assign m1.mem_read = m0.mem_read;
  assign m1.mem_done = m0.mem_done;

  assign rf_a    = regs[ra0];
  assign rf_b    = regs[rb0];
  assign alu_res = aa0 + ab0;

  instruction_unit_q #(
    .DATA_W(32), .FIFO_DEPTH(4), .MEM_TIMEOUT(8), .LDR_SIGN_EXT(0)
  ) u0 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid),
    .instr_in(instr_in), .instr_ready(rdy0),
    .core_ready_flag(crdy0), .alu_busy_flag(abusy0),
    .mem_busy_flag(mbusy0), .instruction_done_flag(done0),
    .illegal_opcode_flag(ill0), .mem_timeout_flag(to0),
    .retired_count(ret0), .rf_addr_a(ra0), .rf_addr_b(rb0),
    .rf_data_a(rf_a), .rf_data_b(rf_b), .rf_wen(wen0),
    .rf_write_addr(wa0), .rf_write_data(wd0), .alu_op(aop0),
    .alu_a(aa0), .alu_b(ab0), .alu_result(alu_res),
    .alu_done(alu_done), .miu(m0)
  );

  instruction_unit_q #(
    .DATA_W(32), .FIFO_DEPTH(4), .MEM_TIMEOUT(8), .LDR_SIGN_EXT(1)
  ) u1 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid),
    .instr_in(instr_in), .instr_ready(rdy1),
    .core_ready_flag(crdy1), .alu_busy_flag(abusy1),
    .mem_busy_flag(mbusy1), .instruction_done_flag(done1),
    .illegal_opcode_flag(ill1), .mem_timeout_flag(to1),
    .retired_count(ret1), .rf_addr_a(ra1), .rf_addr_b(rb1),
    .rf_data_a(rf_a), .rf_data_b(rf_b), .rf_wen(wen1),
    .rf_write_addr(wa1), .rf_write_data(wd1), .alu_op(aop1),
    .alu_a(aa1), .alu_b(ab1), .alu_result(alu_res),
    .alu_done(alu_done), .miu(m1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory and ALU responders
  always @(negedge clk) begin
    if (m0.mem_req) begin
      mcnt++;
      mreq_n++;
      m0.mem_done = mem_en && (mcnt == mem_lat + 1);
      seen_we   = m0.mem_we;
      seen_addr = m0.mem_addr;
      seen_wr   = m0.mem_write;
      if (m0.mem_we !== exp_we || m0.mem_addr !== exp_addr ||
          (exp_we && m0.mem_write !== exp_wr))
        mem_unstable++;
    end else begin
      mcnt = 0;
      m0.mem_done = 1'b0;
    end
    m0.mem_read = rd_val;
    if (abusy0) begin
      acnt++;
      alu_done = !alu_stall && (acnt >= 2);
    end else begin
      acnt = 0;
      alu_done = 1'b0;
    end
  end

  function automatic logic [31:0] mk(input logic [3:0] op,
      input logic [4:0] rt, input logic [4:0] ra,
      input logic [4:0] rb, input logic [12:0] ad);
    return {op, rt, ra, rb, ad};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic pushd(input logic wb, input logic ill,
      input logic to, input logic lat, input int acc);
    dexp_t d;
    d.wb = wb; d.ill = ill; d.to = to; d.lat = lat; d.acc = acc;
    donq.push_back(d);
  endtask

  task automatic pushw(input logic [4:0] a, input logic [31:0] d0,
                       input logic [31:0] d1);
    wexp_t w;
    w.a = a; w.d0 = d0; w.d1 = d1;
    wbq.push_back(w);
  endtask

  task automatic monitor();
    dexp_t d;
    wexp_t w;
    forever begin
      @(negedge clk);
      if (done0) begin
        chk("done_lockstep", done1, 1);
        if (donq.size() == 0) chk("done_unexpected", done0, 0);
        else begin
          d = donq.pop_front();
          chk("done_wen", wen0, d.wb);
          chk("done_illegal", ill0, d.ill);
          chk("done_timeout", to0, d.to);
          if (d.lat) chk("done_latency", cyc - d.acc, 5);
        end
      end else begin
        chk("flag_without_done", {30'd0, ill0, to0}, 0);
      end
      if (wen0) begin
        if (wbq.size() == 0) chk("wen_unexpected", wen0, 0);
        else begin
          w = wbq.pop_front();
          chk("wb_addr", wa0, w.a);
          chk("wb_data", wd0, w.d0);
          chk("wb_wen_sx", wen1, 1);
          chk("wb_data_sx", wd1, w.d1);
        end
      end
    end
  endtask

  task automatic send(input logic [31:0] ins, output int acc);
    int n = 0;
    instr_valid = 1'b1;
    instr_in    = ins;
    while (!rdy0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy0) chk("send_timeout", rdy0, 1);
    @(posedge clk); #1;
    acc = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(crdy0 && donq.size() == 0 && wbq.size() == 0)
               && n < 500);
    chk("idle_reached",
        crdy0 && donq.size() == 0 && wbq.size() == 0, 1);
  endtask

  initial begin
    int acc, n0, first_low, n;
    reset = 1'b1; instr_valid = 1'b0; instr_in = '0;
    alu_stall = 1'b0; mem_en = 1'b1; mem_lat = 1; rd_val = '0;
    exp_we = 1'b0; exp_addr = '0; exp_wr = '0;
    for (int k = 0; k < 32; k++) regs[k] = '0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr_ready", rdy0, 1);
    chk("rst_retired", ret0, 0);
    chk("rst_mem_req", m0.mem_req, 0);
    chk("rst_rf_wen", wen0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_core_ready", crdy0, 1);

    // ADD r3 = r1 + r2
    regs[1] = 32'd5; regs[2] = 32'd7;
    send(mk(OP_ADD, 5'd3, 5'd1, 5'd2, 13'd0), acc);
    instr_valid = 1'b0;
    pushd(1, 0, 0, 1, acc);
    pushw(5'd3, 32'd12, 32'd12);
    wait_idle();
    chk("add_retired", ret0, 1);

    // STR r4 -> 0x10, slow memory
    regs[4] = 32'h1A5;
    exp_we = 1'b1; exp_addr = 13'h10; exp_wr = 8'hA5;
    mem_lat = 3; n0 = mreq_n;
    n = mem_unstable;
    send(mk(OP_STR, 5'd4, 5'd0, 5'd0, 13'h10), acc);
    instr_valid = 1'b0;
    pushd(0, 0, 0, 0, acc);
    wait_idle();
    chk("str_we", seen_we, 1);
    chk("str_addr", seen_addr, 13'h10);
    chk("str_byte", seen_wr, 8'hA5);
    chk("str_stable", mem_unstable - n, 0);
    chk("str_req_cycles", mreq_n - n0, 4);
    chk("str_retired", ret0, 2);

    // LDR r2 <- 0x20, byte 0x80
    exp_we = 1'b0; exp_addr = 13'h20; mem_lat = 1; rd_val = 8'h80;
    send(mk(OP_LDR, 5'd2, 5'd0, 5'd0, 13'h20), acc);
    instr_valid = 1'b0;
    pushd(1, 0, 0, 0, acc);
    pushw(5'd2, 32'h0000_0080, 32'hFFFF_FF80);
    wait_idle();

    // illegal codes and NOP back to back
    send(mk(OP_RES1, 5'd1, 5'd0, 5'd0, 13'd0), acc);
    pushd(0, 1, 0, 0, acc);
    send(mk(4'hF, 5'd1, 5'd0, 5'd0, 13'd0), acc);
    pushd(0, 1, 0, 0, acc);
    send(mk(OP_NOP, 5'd0, 5'd0, 5'd0, 13'd0), acc);
    pushd(0, 0, 0, 0, acc);
    instr_valid = 1'b0;
    wait_idle();
    chk("misc_retired", ret0, 6);

    // LDR with no mem_done: abort after 8 WAIT_MEM cycles
    mem_en = 1'b0; exp_addr = 13'h30; n0 = mreq_n;
    send(mk(OP_LDR, 5'd5, 5'd0, 5'd0, 13'h30), acc);
    instr_valid = 1'b0;
    pushd(0, 0, 1, 0, acc);
    wait_idle();
    chk("timeout_req_cycles", mreq_n - n0, 9);
    chk("timeout_mem_req", m0.mem_req, 0);
    mem_en = 1'b1;

    // stalled ALU, then six back-to-back ADDs
    for (int k = 0; k < 8; k++) regs[k] = 32'h101 * k;
    alu_stall = 1'b1;
    send(mk(OP_ADD, 5'd10, 5'd1, 5'd2, 13'd0), acc);
    instr_valid = 1'b0;
    pushd(1, 0, 0, 0, acc);
    pushw(5'd10, regs[1] + regs[2], regs[1] + regs[2]);
    n = 0;
    while (!abusy0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("alu_busy_seen", abusy0, 1);
    first_low = -1;
    for (int i = 0; i < 6; i++) begin
      if (!rdy0 && first_low < 0) begin
        first_low = i;
        alu_stall = 1'b0;
      end
      send(mk(OP_ADD, 5'(11 + i), 5'(i), 5'(i + 1), 13'd0), acc);
      pushd(1, 0, 0, 0, acc);
      pushw(5'(11 + i), regs[i] + regs[i + 1], regs[i] + regs[i + 1]);
    end
    instr_valid = 1'b0;
    chk("fifo_full_after", first_low, 4);
    wait_idle();
    chk("fifo_retired", ret0, 14);

    // RES1, then reset while an LDR waits on memory
    send(mk(OP_RES1, 5'd7, 5'd0, 5'd0, 13'd0), acc);
    instr_valid = 1'b0;
    pushd(0, 1, 0, 0, acc);
    wait_idle();
    mem_en = 1'b0; exp_addr = 13'h40;
    send(mk(OP_LDR, 5'd6, 5'd0, 5'd0, 13'h40), acc);
    instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_rst_mem_busy", mbusy0, 1);
    send(mk(OP_NOP, 5'd0, 5'd0, 5'd0, 13'd0), acc);
    instr_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_mem_req", m0.mem_req, 0);
    chk("abort_rf_wen", wen0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post_rst_ready", rdy0, 1);
    chk("post_rst_retired", ret0, 0);
    repeat (10) @(negedge clk);
    #1;
    chk("post_rst_fifo_empty", crdy0, 1);
    chk("post_rst_retired_sx", ret1, 0);
    mem_en = 1'b1;

    chk("done_queue_drained", donq.size(), 0);
    chk("wb_queue_drained", wbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end
endmodule
